// File: rtl/rr_int_add_sched.sv
// rr_int_add_sched: round-robin front end for one shared truncating adder.
// Accepts one operand pair per operation from NUM_REQ requesters, adds the
// upper OP_BITWIDTH bits of each operand, and returns the ID-tagged sum
// through a valid/ready response port. Only one operation is in flight.
module rr_int_add_sched #(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int NUM_REQ            = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [1:0]                         resp_id,
  output logic [DATA_PATH_BITWIDTH-1:0]      resp_c
);

  localparam int DPW = DATA_PATH_BITWIDTH;
  localparam int OP  = OP_BITWIDTH;
  localparam int LO  = DPW - OP;  // first bit of the active operand field

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [1:0]      id_q, id_d;
  logic [OP-1:0]   op_a_q, op_a_d;
  logic [OP-1:0]   op_b_q, op_b_d;
  logic [DPW-1:0]  resp_c_q, resp_c_d;

  logic            grant_found;
  logic [1:0]      grant_idx;
  logic [1:0]      cand;
  logic [OP-1:0]   sum;

  // Operand bits below the active field never reach the adder.
  logic            unused_low_bits;
  assign unused_low_bits = ^{req_a, req_b};

  // Shared adder: carry-out is dropped by the OP-wide result.
  assign sum = op_a_q + op_b_q;

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state, operand capture, result register and handshake outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_c_d     = resp_c_q;
    req_ready    = '0;
    resp_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          op_a_d       = req_a[grant_idx*DPW + LO +: OP];
          op_b_d       = req_b[grant_idx*DPW + LO +: OP];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_c_d              = '0;
        resp_c_d[DPW-1 -: OP] = sum;
        state_d               = HOLD;
      end
      HOLD: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_c_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_c_q     <= resp_c_d;
    end
  end

  assign resp_id = id_q;
  assign resp_c  = resp_c_q;

endmodule

// File: tb/tb_rr_int_add_sched.sv
// Directed bench for rr_int_add_sched. A full-width instance is checked
// through a scoreboard of expected {id, sum}; a second instance with a
// 16-bit active field checks field extraction.
module tb_rr_int_add_sched;

  localparam int DPW = 32;

  logic            clk;
  logic            rst;

  // Full-width instance (OP = DPW = 32).
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [4*DPW-1:0] req_a;
  logic [4*DPW-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [DPW-1:0]  resp_c;

  // Narrow-field instance (OP = 16, DPW = 32).
  logic [3:0]      n_req_valid;
  logic [3:0]      n_req_ready;
  logic [4*DPW-1:0] n_req_a;
  logic [4*DPW-1:0] n_req_b;
  logic            n_resp_valid;
  logic            n_resp_ready;
  logic [1:0]      n_resp_id;
  logic [DPW-1:0]  n_resp_c;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  rr_int_add_sched #(
    .OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(DPW), .NUM_REQ(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_c(resp_c)
  );

  rr_int_add_sched #(
    .OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DPW), .NUM_REQ(4)
  ) u_dut_narrow (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_a(n_req_a), .req_b(n_req_b),
    .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
    .resp_id(n_resp_id), .resp_c(n_resp_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a,
                         input logic [31:0] b);
    req_a[i*DPW +: DPW] = a;
    req_b[i*DPW +: DPW] = b;
  endtask

  // Bounded wait until requester id is granted.
  task automatic wait_grant(input int id);
    int n = 0;
    #1;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("grant_wait_%0d", id), {31'b0, req_ready[id]}, 32'd1);
  endtask

  // Bounded wait until every expected response has been consumed.
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  // Scoreboard: push on request handshake, pop and compare on response.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        check("resp_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_resp_id", {30'b0, resp_id}, {30'b0, e.id});
          check("sb_resp_c", resp_c, e.c);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id = 2'(i);
          e.c  = req_a[i*DPW +: DPW] + req_b[i*DPW +: DPW];
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    rst          = 1'b0;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    resp_ready   = 1'b0;
    n_req_valid  = '0;
    n_req_a      = '0;
    n_req_b      = '0;
    n_resp_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_req_ready", {28'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_c", resp_c, 32'd0);
    check("rst_resp_id", {30'b0, resp_id}, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_req_ready", {28'b0, req_ready}, 32'd0);
    check("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("idle_resp_c", resp_c, 32'd0);

    // Narrow field: upper 16 bits added, lower bits ignored.
    n_req_a[2*DPW +: DPW] = 32'h0001_FFFF;
    n_req_b[2*DPW +: DPW] = 32'h0002_0001;
    n_req_valid = 4'b0100;
    #1;
    check("narrow_grant", {28'b0, n_req_ready}, 32'h4);
    tick();
    n_req_valid = '0;
    check("narrow_exec_valid", {31'b0, n_resp_valid}, 32'd0);
    tick();
    check("narrow_hold_valid", {31'b0, n_resp_valid}, 32'd1);
    check("narrow_resp_id", {30'b0, n_resp_id}, 32'd2);
    check("narrow_resp_c", n_resp_c, 32'h0003_0000);
    n_resp_ready = 1'b1;
    tick();
    n_resp_ready = 1'b0;
    check("narrow_done_valid", {31'b0, n_resp_valid}, 32'd0);

    // Strict rotation with all four requesting: a = i, b = 1.
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'd1);
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % 4);
      check($sformatf("rot_grant_%0d", k), {28'b0, req_ready},
            32'(1 << (k % 4)));
      tick();
      if (k == 4) req_valid = '0;
    end
    wait_drain();

    // Wrap-around: carry-out dropped.
    set_ops(1, 32'hFFFF_FFFF, 32'h0000_0002);
    req_valid = 4'b0010;
    wait_grant(1);
    tick();
    req_valid = '0;
    check("wrap_exec_valid", {31'b0, resp_valid}, 32'd0);
    tick();
    check("wrap_hold_valid", {31'b0, resp_valid}, 32'd1);
    check("wrap_resp_c", resp_c, 32'h0000_0001);
    wait_drain();

    // Stall in HOLD with every requester still asking.
    set_ops(1, 32'd1, 32'd1);
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    wait_grant(2);
    check("stall_grant", {28'b0, req_ready}, 32'h4);
    tick();
    tick();
    check("stall_hold_valid", {31'b0, resp_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("stall_resp_id", {30'b0, resp_id}, 32'd2);
      check("stall_resp_c", resp_c, 32'd3);
      check("stall_req_ready", {28'b0, req_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("stall_next_grant", {28'b0, req_ready}, 32'h8);
    tick();
    req_valid = '0;
    wait_drain();

    // Reset during EXEC, then priority restarts at requester 0.
    set_ops(2, 32'd2, 32'd1);
    req_valid = 4'b0100;
    wait_grant(2);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_req_ready", {28'b0, req_ready}, 32'd0);
    check("abort_resp_c", resp_c, 32'd0);
    check("abort_resp_id", {30'b0, resp_id}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    set_ops(0, 32'd7, 32'd8);
    set_ops(3, 32'd9, 32'd9);
    req_valid = 4'b1001;
    #1;
    check("post_rst_grant", {28'b0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
